// File: rtl/alu_pkg.sv
// Shared ALU constants.
// Slice width for the carry-lookahead adder tree.
package alu_pkg;
  localparam int CLA_SLICE_W = 4;
endpackage

// File: rtl/cla4_slice.sv
// Combinational 4-bit carry-lookahead slice.
// Carries are fully expanded sums of products; no ripple path.
module cla4_slice (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       gg,
  output logic       pg,
  output logic       cout
);
  logic [3:0] g;
  logic [3:0] p;
  logic [4:0] c;

  assign g = a & b;
  assign p = a ^ b;

  assign c[0] = cin;
  assign c[1] = g[0]
              | (p[0] & cin);
  assign c[2] = g[1]
              | (p[1] & g[0])
              | (p[1] & p[0] & cin);
  assign c[3] = g[2]
              | (p[2] & g[1])
              | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign c[4] = g[3]
              | (p[3] & g[2])
              | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0])
              | (p[3] & p[2] & p[1] & p[0] & cin);

  // Group terms exclude cin so an upper level can combine them.
  assign pg = &p;
  assign gg = g[3]
            | (p[3] & g[2])
            | (p[3] & p[2] & g[1])
            | (p[3] & p[2] & p[1] & g[0]);

  assign sum  = p ^ c[3:0];
  assign cout = c[4];
endmodule

// File: rtl/cla_adder.sv
// Registered WIDTH-bit carry-lookahead adder.
// 4-bit slices joined by a second lookahead level.
module cla_adder
  import alu_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovfl,
  output logic             Gg,
  output logic             Pg
);
  localparam int NS = WIDTH / CLA_SLICE_W;

  if ((WIDTH % CLA_SLICE_W) != 0 || WIDTH < CLA_SLICE_W) begin : g_bad_width
    $error("cla_adder: WIDTH must be a positive multiple of 4");
  end

  logic [NS-1:0]    gs;
  logic [NS-1:0]    ps;
  logic [NS-1:0]    cos;
  logic [NS-1:0]    cg;
  logic [WIDTH-1:0] s;
  logic             gg_n;
  logic             pg_n;
  logic             co_n;
  logic             ov_n;

  for (genvar k = 0; k < NS; k++) begin : g_slice
    cla4_slice u_slice (
      .a    (A[k*CLA_SLICE_W +: CLA_SLICE_W]),
      .b    (B[k*CLA_SLICE_W +: CLA_SLICE_W]),
      .cin  (cg[k]),
      .sum  (s[k*CLA_SLICE_W +: CLA_SLICE_W]),
      .gg   (gs[k]),
      .pg   (ps[k]),
      .cout (cos[k])
    );
  end

  // Each slice carry is an expanded product over lower groups.
  always_comb begin
    logic acc;
    logic run;
    cg[0] = Cin;
    for (int k = 0; k < NS - 1; k++) begin
      acc = 1'b0;
      run = 1'b1;
      for (int j = k; j >= 0; j--) begin
        acc = acc | (run & gs[j]);
        run = run & ps[j];
      end
      cg[k+1] = acc | (run & Cin);
    end
  end

  always_comb begin
    logic run;
    gg_n = 1'b0;
    run  = 1'b1;
    for (int j = NS - 1; j >= 0; j--) begin
      gg_n = gg_n | (run & gs[j]);
      run  = run & ps[j];
    end
    pg_n = &ps;
  end

  assign co_n = cos[NS-1];
  assign ov_n = co_n ^ (s[WIDTH-1] ^ A[WIDTH-1] ^ B[WIDTH-1]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      Sum  <= '0;
      Cout <= 1'b0;
      Ovfl <= 1'b0;
      Gg   <= 1'b0;
      Pg   <= 1'b0;
    end else begin
      Sum  <= s;
      Cout <= co_n;
      Ovfl <= ov_n;
      Gg   <= gg_n;
      Pg   <= pg_n;
    end
  end
endmodule

// File: tb/tb_cla_adder.sv
// Scoreboard bench for cla_adder (WIDTH=4).
// Driver pushes expectations; monitor pops after each edge.
module tb_cla_adder;
  localparam int W = 4;
  localparam int M = 1 << W;

  typedef struct packed {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovfl;
    logic         gg;
    logic         pg;
  } resp_t;

  logic         clk;
  logic         rst;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovfl;
  logic         gg;
  logic         pg;

  int errors = 0;
  int checks = 0;
  resp_t exp_q[$];

  cla_adder #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .A    (a),
    .B    (b),
    .Cin  (cin),
    .Sum  (sum),
    .Cout (cout),
    .Ovfl (ovfl),
    .Gg   (gg),
    .Pg   (pg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic resp_t model(int x, int y, int c);
    resp_t r;
    int t;
    int sx;
    int sy;
    int st;
    t  = x + y + c;
    sx = (x >= M/2) ? x - M : x;
    sy = (y >= M/2) ? y - M : y;
    st = sx + sy + c;
    r.sum  = W'(t % M);
    r.cout = (t >= M);
    r.ovfl = (st > M/2 - 1) || (st < -(M/2));
    r.gg   = (x + y >= M);
    r.pg   = (x + y == M - 1) && ((x & y) == 0);
    return r;
  endfunction

  function automatic resp_t cur();
    resp_t r;
    r.sum  = sum;
    r.cout = cout;
    r.ovfl = ovfl;
    r.gg   = gg;
    r.pg   = pg;
    return r;
  endfunction

  task automatic check(string name, resp_t act, resp_t req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got sum=%b co=%b ov=%b gg=%b pg=%b want sum=%b co=%b ov=%b gg=%b pg=%b",
               name, act.sum, act.cout, act.ovfl, act.gg, act.pg,
               req.sum, req.cout, req.ovfl, req.gg, req.pg);
    end
  endtask

  task automatic drive(int x, int y, int c, resp_t e);
    @(negedge clk);
    a   = W'(x);
    b   = W'(y);
    cin = c[0];
    exp_q.push_back(e);
  endtask

  // Monitor: any expectation queued before this edge is due now.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() != 0)
        check("scoreboard", cur(), exp_q.pop_front());
    end
  end

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, want 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  resp_t zero;
  resp_t dir_e [5];
  int    dir_v [5][3];

  initial begin
    zero = '0;
    dir_v[0] = '{1, 1, 0};   dir_e[0] = {4'b0010, 1'b0, 1'b0, 1'b0, 1'b0};
    dir_v[1] = '{8, 8, 0};   dir_e[1] = {4'b0000, 1'b1, 1'b1, 1'b1, 1'b0};
    dir_v[2] = '{10, 5, 0};  dir_e[2] = {4'b1111, 1'b0, 1'b0, 1'b0, 1'b1};
    dir_v[3] = '{15, 0, 1};  dir_e[3] = {4'b0000, 1'b1, 1'b0, 1'b0, 1'b1};
    dir_v[4] = '{10, 6, 0};  dir_e[4] = {4'b0000, 1'b1, 1'b0, 1'b1, 1'b0};

    rst = 1'b0;
    a   = '0;
    b   = '0;
    cin = 1'b0;
    #1 rst = 1'b1;
    #1 check("reset_state", cur(), zero);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 5; i++)
      drive(dir_v[i][0], dir_v[i][1], dir_v[i][2], dir_e[i]);
    drain();

    // Leave non-zero outputs, then reset between edges.
    drive(8, 8, 0, model(8, 8, 0));
    drain();
    @(posedge clk);
    #3 rst = 1'b1;
    #1 check("async_reset", cur(), zero);
    @(posedge clk);
    #1 check("reset_hold", cur(), zero);

    // Release with live operands: next edge must load them.
    @(negedge clk);
    a   = 4'd7;
    b   = 4'd9;
    cin = 1'b1;
    rst = 1'b0;
    exp_q.push_back(model(7, 9, 1));
    drain();

    for (int v = 0; v < 2 * M * M; v++)
      drive(v % M, (v / M) % M, v / (M * M), model(v % M, (v / M) % M, v / (M * M)));
    drain();

    for (int i = 0; i < 100; i++) begin
      int x;
      int y;
      int c;
      x = int'($urandom_range(M - 1));
      y = int'($urandom_range(M - 1));
      c = int'($urandom_range(1));
      drive(x, y, c, model(x, y, c));
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
